// File: rtl/fir_interp_pkg.sv
// Shared constants for the 2x interpolating transmit FIR.
//   DATA_W / COEF_W : sample and coefficient widths (signed Q1.14)
//   FRAC_W          : fractional bits removed when rescaling the accumulator
//   PROD_W / ACC_W  : product and accumulator widths
//   H               : 9-tap lowpass prototype, split into even (phase0) and
//                     odd (phase1) polyphase branches by the datapath
//   state_t         : output sequencing FSM states
package fir_interp_pkg;

   localparam int DATA_W = 16;
   localparam int COEF_W = 16;
   localparam int FRAC_W = 14;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = 35;
   localparam int N_DLY  = 5;

   localparam logic signed [COEF_W-1:0] H [0:8] = '{
      16'sh04F6, 16'sh0AE4, 16'sh1089, 16'sh1496, 16'sh160F,
      16'sh1496, 16'sh1089, 16'sh0AE4, 16'sh04F6
   };

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PH0  = 2'd1,
      S_PH1  = 2'd2
   } state_t;

endpackage

// File: rtl/fir_round_sat.sv
// Rescales one polyphase accumulator to an output sample.
// Adds half an LSB, shifts right arithmetically by FRAC_W, then narrows to
// DATA_W bits.
//   Macro FIR_INTERP_SAT_EN defined   : clamp to the signed DATA_W range.
//   Macro FIR_INTERP_SAT_EN undefined : keep the low DATA_W bits (wrap).
// Ports:
//   acc_in     in  ACC_W   signed accumulator
//   sample_out out DATA_W  rounded Q1.14 sample
module fir_round_sat
   import fir_interp_pkg::*;
(
   input  logic signed [ACC_W-1:0]  acc_in,
   output logic        [DATA_W-1:0] sample_out
);

   localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC_W - 1);

   logic signed [ACC_W-1:0] rounded;

`ifdef FIR_INTERP_SAT_EN
   localparam logic signed [ACC_W-1:0] MAX_V = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] MIN_V = -(ACC_W'(1) << (DATA_W - 1));

   logic signed [ACC_W-1:0] shifted;

   always_comb begin
      rounded = acc_in + RND;
      shifted = rounded >>> FRAC_W;
      if (shifted > MAX_V) begin
         sample_out = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (shifted < MIN_V) begin
         sample_out = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         sample_out = shifted[DATA_W-1:0];
      end
   end
`else
   always_comb begin
      rounded    = acc_in + RND;
      sample_out = DATA_W'(rounded >>> FRAC_W);
   end
`endif

endmodule

// File: rtl/fir_interp2_tx.sv
// Transmit-side 2x polyphase interpolating lowpass FIR.
// Each accepted input sample produces two outputs: phase0 (even taps over
// d[0..4]) followed by phase1 (odd taps over d[0..3]).
// Build option: FIR_INTERP_SAT_EN selects clamping instead of wrap on the
// rescaled result (see fir_round_sat).
// Ports:
//   CLK        in   1       system clock, rising edge
//   RST        in   1       synchronous active-high reset
//   In_Sample  in   DATA_W  input sample, Q1.14
//   In_Valid   in   1       In_Sample valid
//   In_Ready   out  1       input accepted this cycle when In_Valid
//   Out_Sample out  DATA_W  interpolated sample, Q1.14
//   Out_Valid  out  1       Out_Sample valid
//   Out_Ready  in   1       downstream takes Out_Sample this cycle
//
// state  | meaning
// S_IDLE | waiting for an input sample, In_Ready high
// S_PH0  | new sample in delay line, load phase0 when output is free
// S_PH1  | load phase1 when output is free; may accept the next sample
module fir_interp2_tx
   import fir_interp_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] In_Sample,
   input  logic              In_Valid,
   output logic              In_Ready,
   output logic [DATA_W-1:0] Out_Sample,
   output logic              Out_Valid,
   input  logic              Out_Ready
);

   state_t                   state_q, state_d;
   logic signed [DATA_W-1:0] d_q [0:N_DLY-1];
   logic signed [DATA_W-1:0] d_d [0:N_DLY-1];
   logic        [DATA_W-1:0] out_sample_q, out_sample_d;
   logic                     out_valid_q, out_valid_d;

   logic signed [ACC_W-1:0]  acc_ph0, acc_ph1;
   logic signed [PROD_W-1:0] prod;
   logic        [DATA_W-1:0] ph0_sample, ph1_sample;
   logic                     out_free;
   logic                     in_ready;

   // Both branches work from the current (pre-shift) delay line, so phase1
   // of a pair is unaffected by a sample accepted in the same cycle.
   always_comb begin
      acc_ph0 = '0;
      acc_ph1 = '0;
      prod    = '0;
      for (int k = 0; k < N_DLY; k++) begin
         prod    = PROD_W'(d_q[k]) * PROD_W'(H[2*k]);
         acc_ph0 = acc_ph0 + ACC_W'(prod);
      end
      for (int k = 0; k < N_DLY - 1; k++) begin
         prod    = PROD_W'(d_q[k]) * PROD_W'(H[2*k+1]);
         acc_ph1 = acc_ph1 + ACC_W'(prod);
      end
   end

   fir_round_sat u_rs_ph0 (
      .acc_in     (acc_ph0),
      .sample_out (ph0_sample)
   );

   fir_round_sat u_rs_ph1 (
      .acc_in     (acc_ph1),
      .sample_out (ph1_sample)
   );

   always_comb begin
      out_free     = !out_valid_q || Out_Ready;
      state_d      = state_q;
      d_d          = d_q;
      out_sample_d = out_sample_q;
      // a consumed sample drops valid unless something reloads it below
      out_valid_d  = out_valid_q && !Out_Ready;
      in_ready     = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (In_Valid) begin
               d_d[0] = $signed(In_Sample);
               for (int k = 1; k < N_DLY; k++) d_d[k] = d_q[k-1];
               state_d = S_PH0;
            end
         end
         S_PH0: begin
            if (out_free) begin
               out_sample_d = ph0_sample;
               out_valid_d  = 1'b1;
               state_d      = S_PH1;
            end
         end
         S_PH1: begin
            in_ready = out_free;
            if (out_free) begin
               out_sample_d = ph1_sample;
               out_valid_d  = 1'b1;
               if (In_Valid) begin
                  d_d[0] = $signed(In_Sample);
                  for (int k = 1; k < N_DLY; k++) d_d[k] = d_q[k-1];
                  state_d = S_PH0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         for (int k = 0; k < N_DLY; k++) d_q[k] <= '0;
         out_sample_q <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         d_q          <= d_d;
         out_sample_q <= out_sample_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign In_Ready   = in_ready && !RST;
   assign Out_Sample = out_sample_q;
   assign Out_Valid  = out_valid_q;

endmodule
